flappy_game_ctrl: RTL and testbench

- Game sequencer driving the VGA pixel painter: owns bird position and vertical velocity, pipe scroll and gap height, collision detection, score and game state.
- Its outputs feed the painter's BirbX/BirbY/PipeX/PipeY inputs. Coordinates are in hCount/vCount space: visible h 144..783, v 35..514.
- All motion updates happen on an internal physics tick.

---
 rtl/flappy_game_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: game sequencer for the VGA flappy-bird painter.
// Owns bird height and vertical velocity, pipe scroll and gap height,
// collision detection, score and game state. All motion advances on a
// physics tick derived from clk by TICK_DIV.
// Optional build macro FLAPPY_INVINCIBLE_EN: ceiling and pipe deaths are
// disabled and the floor only clamps, so DEAD is never entered.
module flappy_game_ctrl #(
  parameter int TICK_DIV     = 500000,
  parameter int BIRD_X       = 400,
  parameter int BIRD_Y0      = 260,
  parameter int FLAP_VEL     = 6,
  parameter int VMAX         = 8,
  parameter int PIPE_SPEED   = 2,
  parameter int PIPE_X_START = 834,
  parameter int PIPE_X_END   = 94,
  parameter int GAP          = 100,
  parameter int DEAD_HOLD    = 50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        button,
  output logic [9:0]  BirbX,
  output logic [9:0]  BirbY,
  output logic [9:0]  PipeX,
  output logic [9:0]  PipeY,
  output logic [15:0] score,
  output logic [1:0]  state,
  output logic        tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DC_W  = $clog2(DEAD_HOLD + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DC_W-1:0]  DEAD_LAST = DC_W'(DEAD_HOLD);
  localparam logic [9:0]       LFSR_SEED = 10'h2A5;
  // Galois feedback mask for x^10 + x^7 + 1 (right-shifting form)
  localparam logic [9:0]       LFSR_TAPS = 10'h240;
  localparam logic [9:0]       PIPE_Y0   = 10'd200;
  localparam logic [9:0]       GAP_BASE  = 10'd60;
  localparam logic [9:0]       BIRD_Y0_V = 10'(BIRD_Y0);
  localparam logic [9:0]       PIPE_X0_V = 10'(PIPE_X_START);

  // Signed 11-bit coordinate constants; the floor is 514 minus the 25 px bird
  localparam logic signed [10:0] V_TOP   = 11'sd35;
  localparam logic signed [10:0] V_FLOOR = 11'sd489;
  localparam logic signed [10:0] BIRD_L  = 11'(BIRD_X);
  localparam logic signed [10:0] BIRD_R  = 11'(BIRD_X + 50);
  localparam logic signed [10:0] X_END   = 11'(PIPE_X_END);
  localparam logic signed [10:0] X_START = 11'(PIPE_X_START);
  localparam logic signed [10:0] GAP_S   = 11'(GAP);
  localparam logic signed [10:0] SPEED_S = 11'(PIPE_SPEED);
  localparam logic signed [4:0]  VEL_FLAP = 5'(-FLAP_VEL);
  localparam logic signed [4:0]  VEL_MAX  = 5'(VMAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_DEAD = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic               btn_meta_q, btn_sync_q, btn_prev_q;
  logic               flap_req_q, flap_req_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [9:0]         lfsr_q, lfsr_d;
  logic signed [4:0]  vel_q, vel_d;
  logic [DC_W-1:0]    dead_cnt_q, dead_cnt_d;
  logic [9:0]         birb_y_q, birb_y_d;
  logic [9:0]         pipe_x_q, pipe_x_d;
  logic [9:0]         pipe_y_q, pipe_y_d;
  logic [15:0]        score_q, score_d;

  logic               btn_rise;
  logic signed [4:0]  vel_new;
  logic signed [10:0] birb_next, birb_post;
  logic signed [10:0] px_pre, px_move, px_post, py_post;
  logic               hit_top, hit_floor, hit_pipe, respawn, passed, die;

  assign tick  = (div_q == DIV_LAST);
  assign BirbX = 10'(BIRD_X);
  assign BirbY = birb_y_q;
  assign PipeX = pipe_x_q;
  assign PipeY = pipe_y_q;
  assign score = score_q;
  assign state = state_q;

  // Next-state logic: candidate physics results are always computed, and
  // only committed to the state registers in tick cycles.
  always_comb begin
    btn_rise = btn_sync_q & ~btn_prev_q;
    div_d    = tick ? '0 : div_q + 1'b1;
    lfsr_d   = {1'b0, lfsr_q[9:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 10'd0);

    if (flap_req_q)           vel_new = VEL_FLAP;
    else if (vel_q < VEL_MAX) vel_new = vel_q + 5'sd1;
    else                      vel_new = VEL_MAX;

    birb_next = $signed({1'b0, birb_y_q}) + $signed({{6{vel_new[4]}}, vel_new});
    hit_top   = (birb_next < V_TOP);
    hit_floor = (birb_next > V_FLOOR);
    if (hit_top)        birb_post = V_TOP;
    else if (hit_floor) birb_post = V_FLOOR;
    else                birb_post = birb_next;

    px_pre  = $signed({1'b0, pipe_x_q});
    px_move = px_pre - SPEED_S;
    respawn = (px_move <= X_END);
    px_post = respawn ? X_START : px_move;
    py_post = respawn ? $signed({1'b0, GAP_BASE + {2'b00, lfsr_q[7:0]}})
                      : $signed({1'b0, pipe_y_q});
    passed  = !respawn && (px_pre >= BIRD_L) && (px_move < BIRD_L);

    hit_pipe = (BIRD_R >= px_post - 11'sd50) && (BIRD_L <= px_post + 11'sd50) &&
               ((birb_post <= py_post) || (birb_post + 11'sd25 >= py_post + GAP_S));

`ifdef FLAPPY_INVINCIBLE_EN
    die = 1'b0;
`else
    die = hit_top | hit_floor | hit_pipe;
`endif

    state_d    = state_q;
    vel_d      = vel_q;
    dead_cnt_d = dead_cnt_q;
    birb_y_d   = birb_y_q;
    pipe_x_d   = pipe_x_q;
    pipe_y_d   = pipe_y_q;
    score_d    = score_q;

    // Several edges between ticks collapse into one request; an edge in the
    // tick cycle itself is kept for the following tick.
    flap_req_d = tick ? btn_rise : (flap_req_q | btn_rise);
    if ((state_q == ST_DEAD) && (dead_cnt_q < DEAD_LAST)) flap_req_d = 1'b0;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          // The starting flap moves the bird immediately; the pipe starts
          // scrolling on the first PLAY tick.
          if (flap_req_q) begin
            state_d  = ST_PLAY;
            vel_d    = vel_new;
            birb_y_d = 10'(birb_post);
            score_d  = 16'd0;
          end
        end
        ST_PLAY: begin
          vel_d    = vel_new;
          birb_y_d = 10'(birb_post);
          pipe_x_d = 10'(px_post);
          pipe_y_d = 10'(py_post);
          if (passed && (score_q != 16'hFFFF)) score_d = score_q + 16'd1;
          if (die) begin
            state_d    = ST_DEAD;
            dead_cnt_d = '0;
          end
        end
        ST_DEAD: begin
          if (dead_cnt_q < DEAD_LAST) begin
            dead_cnt_d = dead_cnt_q + 1'b1;
          end else if (flap_req_q) begin
            state_d  = ST_IDLE;
            vel_d    = 5'sd0;
            birb_y_d = BIRD_Y0_V;
            pipe_x_d = PIPE_X0_V;
            pipe_y_d = PIPE_Y0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers, button synchronizer and edge detector; everything
  // returns to its reset value as soon as reset_n falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      btn_prev_q <= 1'b0;
      flap_req_q <= 1'b0;
      div_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      vel_q      <= 5'sd0;
      dead_cnt_q <= '0;
      birb_y_q   <= BIRD_Y0_V;
      pipe_x_q   <= PIPE_X0_V;
      pipe_y_q   <= PIPE_Y0;
      score_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      btn_meta_q <= button;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_sync_q;
      flap_req_q <= flap_req_d;
      div_q      <= div_d;
      lfsr_q     <= lfsr_d;
      vel_q      <= vel_d;
      dead_cnt_q <= dead_cnt_d;
      birb_y_q   <= birb_y_d;
      pipe_x_q   <= pipe_x_d;
      pipe_y_q   <= pipe_y_d;
      score_q    <= score_d;
    end
  end

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb_flappy_game_ctrl: directed bench for flappy_game_ctrl with TICK_DIV=4.
// A tick-level behavioural model tracks bird, pipe, score and state; key
// points (first flap trajectory, floor, scoring step, respawn, DEAD hold,
// async reset) are also checked against hand-computed constants.
module tb_flappy_game_ctrl;

  localparam int TICKS = 4;
`ifdef FLAPPY_INVINCIBLE_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        button;
  logic [9:0]  BirbX, BirbY, PipeX, PipeY;
  logic [15:0] score;
  logic [1:0]  state;
  logic        tick;

  int check_count = 0;
  int fail_count  = 0;

  int m_state, m_by, m_vel, m_px, m_py, m_score, m_dcnt;
  bit m_flap;

  flappy_game_ctrl #(.TICK_DIV(TICKS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .button  (button),
    .BirbX   (BirbX),
    .BirbY   (BirbY),
    .PipeX   (PipeX),
    .PipeY   (PipeY),
    .score   (score),
    .state   (state),
    .tick    (tick)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  // Watchdog so a stuck design still ends the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    check_count++;
    if (got != exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One button press held for 3 clocks, running alongside the tick waits
  task automatic applyStimulus();
    m_flap = 1'b1;
    fork
      begin
        button = 1'b1;
        repeat (3) @(posedge clk);
        #1 button = 1'b0;
      end
    join_none
  endtask

  task automatic model_init();
    m_state = 0; m_by = 260; m_vel = 0; m_px = 834; m_py = 200;
    m_score = 0; m_dcnt = 0; m_flap = 1'b0;
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    button  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_init();
  endtask

  // Waits for a tick pulse (bounded), then returns 1 ns after the tick edge.
  task automatic wait_tick(output int n);
    n = 1;
    @(negedge clk);
    while (tick !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) checkOutput("tick_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Game behaviour advanced by one physics tick; m_py < 0 means the gap
  // height came from the LFSR and is only range-checked.
  task automatic model_tick();
    int nv, nb, npx;
    bit die;
    case (m_state)
      0: if (m_flap) begin
        m_state = 1; m_vel = -6; m_by = m_by - 6; m_score = 0;
      end
      1: begin
        nv = m_flap ? -6 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
        m_vel = nv;
        nb = m_by + nv;
        die = 1'b0;
        if (nb < 35) begin nb = 35; die = !INV; end
        else if (nb > 489) begin nb = 489; die = !INV; end
        npx = m_px - 2;
        if (npx <= 94) begin
          npx = 834; m_py = -1;
        end else if (m_px >= 400 && npx < 400 && m_score < 65535) begin
          m_score++;
        end
        m_by = nb;
        m_px = npx;
        if (!INV && m_py >= 0 && 450 >= m_px - 50 && 400 <= m_px + 50 &&
            (m_by <= m_py || m_by + 25 >= m_py + 100)) die = 1'b1;
        if (die) begin m_state = 2; m_dcnt = 0; end
      end
      2: begin
        if (m_dcnt < 50) m_dcnt++;
        else if (m_flap) begin
          m_state = 0; m_by = 260; m_px = 834; m_py = 200; m_vel = 0;
        end
      end
      default: ;
    endcase
    m_flap = 1'b0;
  endtask

  task automatic check_model(input string tag);
    checkOutput({tag, "_birby"}, int'(BirbY), m_by);
    checkOutput({tag, "_pipex"}, int'(PipeX), m_px);
    checkOutput({tag, "_state"}, int'(state), m_state);
    checkOutput({tag, "_score"}, int'(score), m_score);
    if (m_py >= 0) checkOutput({tag, "_pipey"}, int'(PipeY), m_py);
  endtask

  task automatic do_tick(input string tag);
    int n;
    wait_tick(n);
    model_tick();
    check_model(tag);
  endtask

  initial begin
    int n;
    int exp_y[4];
    bit respawned;
    exp_y = '{254, 249, 245, 242};

    $display("[TB] start, INV=%0d", INV);

    // ---- reset values -------------------------------------------------
    reset_n = 1'b0;
    button  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_birbx", int'(BirbX), 400);
    checkOutput("rst_birby", int'(BirbY), 260);
    checkOutput("rst_pipex", int'(PipeX), 834);
    checkOutput("rst_pipey", int'(PipeY), 200);
    checkOutput("rst_score", int'(score), 0);
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_tick",  int'(tick), 0);
    applyReset();

    // ---- tick period and idle hold --------------------------------------
    wait_tick(n);
    model_tick();
    checkOutput("tick_low_after", int'(tick), 0);
    wait_tick(n);
    model_tick();
    checkOutput("tick_period", n, TICKS);
    check_model("idle");

    // ---- first flap and upward trajectory -------------------------------
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      do_tick("flap");
      checkOutput($sformatf("flap_y%0d", i), int'(BirbY), exp_y[i]);
    end
    checkOutput("flap_state", int'(state), 1);

    // ---- free fall to the floor ------------------------------------------
    for (int i = 0; i < 60 && m_by != 489; i++) do_tick("fall");
    checkOutput("floor_y", int'(BirbY), 489);
`ifdef FLAPPY_INVINCIBLE_EN
    checkOutput("floor_state", int'(state), 1);
`else
    checkOutput("floor_state", int'(state), 2);
`endif
    for (int i = 0; i < 3; i++) do_tick("frozen");

    // ---- fly through the gap: scoring step and respawn -------------------
    repeat (5) @(posedge clk);
    applyReset();
    applyStimulus();
    do_tick("enter");
    checkOutput("enter_y", int'(BirbY), 254);
    applyStimulus();
    respawned = 1'b0;
    for (int i = 0; i < 400 && !respawned && m_state == 1; i++) begin
      do_tick("gap");
      if (m_px == 402) checkOutput("score_at_402", int'(score), 0);
      if (m_px == 400) checkOutput("score_at_400", int'(score), 0);
      if (m_px == 398) checkOutput("score_at_398", int'(score), 1);
      if (m_px == 834) respawned = 1'b1;
      else if (m_by >= 244) applyStimulus();
    end
    checkOutput("respawn_seen", int'(respawned), 1);
    checkOutput("respawn_x", int'(PipeX), 834);
    checkOutput("respawn_gap_range", int'(PipeY >= 10'd60 && PipeY <= 10'd315), 1);
    checkOutput("respawn_score", int'(score), 1);

`ifndef FLAPPY_INVINCIBLE_EN
    // ---- death with score held, DEAD hold window -------------------------
    for (int i = 0; i < 80 && m_state == 1; i++) do_tick("fall2");
    checkOutput("dead2_state", int'(state), 2);
    checkOutput("dead2_score", int'(score), 1);
    applyStimulus();
    for (int i = 1; i <= 51; i++) begin
      do_tick("hold");
      if (i == 2)  checkOutput("early_flap_ignored", int'(state), 2);
      if (i == 49) applyStimulus();
      if (i == 51) checkOutput("late_flap_ignored", int'(state), 2);
    end
    applyStimulus();
    do_tick("restart");
    checkOutput("restart_state", int'(state), 0);
    checkOutput("restart_score", int'(score), 1);
    checkOutput("restart_y", int'(BirbY), 260);
    checkOutput("restart_x", int'(PipeX), 834);
    checkOutput("restart_py", int'(PipeY), 200);
    applyStimulus();
    do_tick("replay");
    checkOutput("replay_state", int'(state), 1);
    checkOutput("replay_score", int'(score), 0);
    checkOutput("replay_y", int'(BirbY), 254);
`endif

    // ---- pipe overlap with the bird above the gap ------------------------
    repeat (5) @(posedge clk);
    applyReset();
    applyStimulus();
    for (int i = 0; i < 250 && (m_state == 0 || (m_state == 1 && m_px > 500)); i++) begin
      do_tick("hit");
      if (m_state == 1 && m_by >= 150) applyStimulus();
    end
    checkOutput("hit_pipex", int'(PipeX), 500);
    checkOutput("hit_pipey", int'(PipeY), 200);
`ifdef FLAPPY_INVINCIBLE_EN
    checkOutput("hit_state", int'(state), 1);
`else
    checkOutput("hit_state", int'(state), 2);
`endif

    // ---- asynchronous reset mid-play --------------------------------------
    repeat (5) @(posedge clk);
    applyReset();
    applyStimulus();
    for (int i = 0; i < 5; i++) do_tick("pre_arst");
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checkOutput("arst_birby", int'(BirbY), 260);
    checkOutput("arst_pipex", int'(PipeX), 834);
    checkOutput("arst_pipey", int'(PipeY), 200);
    checkOutput("arst_state", int'(state), 0);
    checkOutput("arst_score", int'(score), 0);
    checkOutput("arst_tick",  int'(tick), 0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", check_count, fail_count);
    $finish;
  end

endmodule
